// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - serial float dot product y = b + sum(x_i*w_i) built on one multiplier and one adder core.
// Both cores register their result one cycle after start and flush subnormals to zero.

module mul_float #(
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] y,
  output logic                   done,
  output logic                   overflow,
  output logic                   nan
);
  localparam int EW = (FLOAT_WIDTH == 64) ? 11 : ((FLOAT_WIDTH == 16) ? 5 : 8);
  localparam int MW = FLOAT_WIDTH - EW - 1;
  localparam logic [EW-1:0] EMAX = '1;
  localparam logic signed [EW+1:0] BIAS = (EW+2)'((1 << (EW - 1)) - 1);

  logic                   sa, sb, sr;
  logic [EW-1:0]          ea, eb;
  logic [MW-1:0]          fa, fb;
  logic [2*MW+1:0]        prod;
  logic [2*MW:0]          pn;
  logic [MW:0]            frac_r;
  logic                   rnd;
  logic signed [EW+1:0]   e, e_f;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [FLOAT_WIDTH-1:0] r;
  logic                   r_ovf, r_nan;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    sr     = sa ^ sb;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);
    prod   = {{(MW+1){1'b0}}, 1'b1, fa} * {{(MW+1){1'b0}}, 1'b1, fb};
    // pn drops the leading one: fraction, guard, then sticky bits
    pn     = prod[2*MW+1] ? prod[2*MW:0] : {prod[2*MW-1:0], 1'b0};
    e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
           + $signed({{(EW+1){1'b0}}, prod[2*MW+1]});
    rnd    = pn[MW] & ((|pn[MW-1:0]) | pn[MW+1]);
    frac_r = {1'b0, pn[2*MW:MW+1]} + {{MW{1'b0}}, rnd};
    e_f    = e + $signed({{(EW+1){1'b0}}, frac_r[MW]});
    r_ovf  = 1'b0;
    r_nan  = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r     = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
      r_nan = 1'b1;
    end else if (a_inf || b_inf) begin
      r = {sr, EMAX, {MW{1'b0}}};
    end else if (a_zero || b_zero) begin
      r = {sr, {(FLOAT_WIDTH-1){1'b0}}};
    end else if (e_f >= $signed({2'b00, EMAX})) begin
      r     = {sr, EMAX, {MW{1'b0}}};
      r_ovf = 1'b1;
    end else if (e_f <= $signed({(EW+2){1'b0}})) begin
      r = {sr, {(FLOAT_WIDTH-1){1'b0}}};
    end else begin
      r = {sr, e_f[EW-1:0], frac_r[MW-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      nan      <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        y        <= r;
        overflow <= r_ovf;
        nan      <= r_nan;
      end
    end
  end
endmodule

module add_float #(
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   add_sub,
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] y,
  output logic                   done,
  output logic                   overflow,
  output logic                   nan
);
  localparam int EW = (FLOAT_WIDTH == 64) ? 11 : ((FLOAT_WIDTH == 16) ? 5 : 8);
  localparam int MW = FLOAT_WIDTH - EW - 1;
  localparam int W  = MW + 4;
  localparam logic [EW-1:0] EMAX = '1;

  logic                   sa, sb, sbe, sg, ss;
  logic [EW-1:0]          ea, eb, eg, es, d;
  logic [MW-1:0]          fa, fb;
  logic                   a_ge, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [W-1:0]           mg, ms, sh, lo, sh_st, m;
  logic [W:0]             s;
  logic [EW+1:0]          lz;
  logic                   found, rnd;
  logic [MW:0]            frac_r;
  logic signed [EW+1:0]   e, e_f;
  logic [FLOAT_WIDTH-1:0] r;
  logic                   r_ovf, r_nan;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    sbe    = sb ^ add_sub;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);
    a_ge   = ({ea, fa} >= {eb, fb});
    sg     = a_ge ? sa : sbe;
    ss     = a_ge ? sbe : sa;
    eg     = a_ge ? ea : eb;
    es     = a_ge ? eb : ea;
    mg     = a_ge ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
    ms     = a_ge ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
    d      = eg - es;
    {sh, lo} = {ms, {W{1'b0}}} >> d;
    // bits shifted past the guard/round positions collapse into a sticky bit
    if (d >= W) sh_st = {{(W-1){1'b0}}, 1'b1};
    else        sh_st = {sh[W-1:1], sh[0] | (|lo)};
    if (sg == ss) s = {1'b0, mg} + {1'b0, sh_st};
    else          s = {1'b0, mg} - {1'b0, sh_st};
    if (s[W]) m = {s[W:2], s[1] | s[0]};
    else      m = s[W-1:0];
    lz    = '0;
    found = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      if (!found) begin
        if (m[k]) found = 1'b1;
        else      lz = lz + 1'b1;
      end
    end
    m      = m << lz;
    e      = $signed({2'b00, eg}) + $signed({{(EW+1){1'b0}}, s[W]}) - $signed(lz);
    rnd    = m[2] & (m[1] | m[0] | m[3]);
    frac_r = {1'b0, m[W-2:3]} + {{MW{1'b0}}, rnd};
    e_f    = e + $signed({{(EW+1){1'b0}}, frac_r[MW]});
    r_ovf  = 1'b0;
    r_nan  = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) begin
      r     = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
      r_nan = 1'b1;
    end else if (a_inf) begin
      r = {sa, EMAX, {MW{1'b0}}};
    end else if (b_inf) begin
      r = {sbe, EMAX, {MW{1'b0}}};
    end else if (a_zero && b_zero) begin
      r = {sa & sbe, {(FLOAT_WIDTH-1){1'b0}}};
    end else if (a_zero) begin
      r = {sbe, eb, fb};
    end else if (b_zero) begin
      r = a;
    end else if (!found || e_f <= $signed({(EW+2){1'b0}})) begin
      r = {(FLOAT_WIDTH){1'b0}};
    end else if (e_f >= $signed({2'b00, EMAX})) begin
      r     = {sg, EMAX, {MW{1'b0}}};
      r_ovf = 1'b1;
    end else begin
      r = {sg, e_f[EW-1:0], frac_r[MW-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      nan      <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        y        <= r;
        overflow <= r_ovf;
        nan      <= r_nan;
      end
    end
  end
endmodule

module neuron_mac #(
  parameter int S = 32,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S*N-1:0] x,
  input  logic [S*N-1:0] w,
  input  logic [S-1:0] b,
  output logic [S-1:0] y,
  output logic         done,
  output logic         busy,
  output logic         ovf,
  output logic         nan
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, MUL_GO, MUL_WAIT, ADD_GO, ADD_WAIT, FIN} state_t;

  state_t         state, state_nxt;
  logic [S*N-1:0] x_r, w_r;
  logic [S-1:0]   acc, prod;
  logic [IW-1:0]  idx;
  logic           accept;
  logic [S-1:0]   mul_y, add_y;
  logic           mul_done, mul_ovf, mul_nan;
  logic           add_done, add_ovf, add_nan;

  assign accept = start && (state == IDLE || state == FIN);
  assign busy   = !(state == IDLE || state == FIN);

  mul_float #(.FLOAT_WIDTH(S)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == MUL_GO),
    .a        (x_r[idx*S +: S]),
    .b        (w_r[idx*S +: S]),
    .y        (mul_y),
    .done     (mul_done),
    .overflow (mul_ovf),
    .nan      (mul_nan)
  );

  add_float #(.FLOAT_WIDTH(S)) u_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == ADD_GO),
    .add_sub  (1'b0),
    .a        (acc),
    .b        (prod),
    .y        (add_y),
    .done     (add_done),
    .overflow (add_ovf),
    .nan      (add_nan)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: if (start) state_nxt = MUL_GO;
      MUL_GO:    state_nxt = MUL_WAIT;
      MUL_WAIT:  if (mul_done) state_nxt = ADD_GO;
      ADD_GO:    state_nxt = ADD_WAIT;
      ADD_WAIT:  if (add_done) state_nxt = (idx == LAST) ? FIN : MUL_GO;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r  <= '0;
      w_r  <= '0;
      acc  <= '0;
      prod <= '0;
      idx  <= '0;
      y    <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
      nan  <= 1'b0;
    end else if (accept) begin
      x_r  <= x;
      w_r  <= w;
      acc  <= b;
      idx  <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
      nan  <= 1'b0;
    end else begin
      ovf <= ovf | (mul_done & mul_ovf) | (add_done & add_ovf);
      nan <= nan | (mul_done & mul_nan) | (add_done & add_nan);
      case (state)
        MUL_WAIT: if (mul_done) prod <= mul_y;
        ADD_WAIT: begin
          if (add_done) begin
            acc <= add_y;
            if (idx != LAST) idx <= idx + 1'b1;
          end
        end
        FIN: begin
          y    <= acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed checks of neuron_mac against hand-computed float results.

module tb_neuron_mac;
  localparam int S   = 32;
  localparam int N   = 2;
  localparam int LAT = N * (1 + 1 + 2) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [S*N-1:0] x, w;
  logic [S-1:0]   b;
  logic [S-1:0]   y;
  logic           done, busy, ovf, nan;

  int   n_checks = 0;
  int   n_errors = 0;
  int   rise_cnt = 0;
  int   lat;
  logic done_prev = 1'b0;

  neuron_mac #(.S(S), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .w     (w),
    .b     (b),
    .y     (y),
    .done  (done),
    .busy  (busy),
    .ovf   (ovf),
    .nan   (nan)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done && !done_prev) rise_cnt++;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [S*N-1:0] xv, input logic [S*N-1:0] wv, input logic [S-1:0] bv);
    @(negedge clk);
    x = xv; w = wv; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; x = '0; w = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y", y, 32'h0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_nan", {31'b0, nan}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_no_start", {31'b0, busy}, 32'd0);

    // 1*0.5 + 2*0.25 + 1 = 2.0
    launch({32'h40000000, 32'h3f800000}, {32'h3e800000, 32'h3f000000}, 32'h3f800000);
    check("busy_run", {31'b0, busy}, 32'd1);
    wait_done(lat);
    check("lat_basic", lat, LAT);
    check("y_basic", y, 32'h40000000);
    check("ovf_basic", {31'b0, ovf}, 32'd0);
    check("nan_basic", {31'b0, nan}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {31'b0, done}, 32'd1);
    check("busy_fin", {31'b0, busy}, 32'd0);

    // 1*-1 + 1*-2 + 0 = -3.0
    launch({32'h3f800000, 32'h3f800000}, {32'hc0000000, 32'hbf800000}, 32'h0);
    wait_done(lat);
    check("y_neg", y, 32'hc0400000);

    // max_float * 2 overflows to +inf
    launch({32'h0, 32'h7f7fffff}, {32'h0, 32'h40000000}, 32'h0);
    wait_done(lat);
    check("ovf_set", {31'b0, ovf}, 32'd1);
    check("y_ovf", y, 32'h7f800000);
    check("nan_ovf", {31'b0, nan}, 32'd0);
    launch({32'h40000000, 32'h3f800000}, {32'h3e800000, 32'h3f000000}, 32'h3f800000);
    check("ovf_clear", {31'b0, ovf}, 32'd0);
    check("done_clear", {31'b0, done}, 32'd0);
    wait_done(lat);
    check("y_after_ovf", y, 32'h40000000);

    // quiet NaN input raises the nan flag
    launch({32'h0, 32'h7fc00000}, {32'h0, 32'h3f800000}, 32'h0);
    wait_done(lat);
    check("nan_set", {31'b0, nan}, 32'd1);
    check("ovf_nan", {31'b0, ovf}, 32'd0);

    // second start while busy must be ignored
    launch({32'h3f800000, 32'h3f800000}, {32'hc0000000, 32'hbf800000}, 32'h0);
    rise_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    x = {32'h40000000, 32'h3f800000}; b = 32'h3f800000; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(lat);
    check("lat_ignore", lat, LAT - 3);
    repeat (12) @(posedge clk);
    #1;
    check("y_ignore", y, 32'hc0400000);
    check("one_done_rise", rise_cnt, 32'd1);
    check("busy_ignore", {31'b0, busy}, 32'd0);

    // reset during MUL_WAIT
    launch({32'h40000000, 32'h3f800000}, {32'h3e800000, 32'h3f000000}, 32'h3f800000);
    @(posedge clk);
    #1;
    check("busy_mulwait", {31'b0, busy}, 32'd1);
    check("y_held", y, 32'hc0400000);
    rst_n = 1'b0;
    #1;
    check("mrst_y", y, 32'h0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_ovf", {31'b0, ovf}, 32'd0);
    check("mrst_nan", {31'b0, nan}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_done", {31'b0, done}, 32'd0);
    launch({32'h40000000, 32'h3f800000}, {32'h3e800000, 32'h3f000000}, 32'h3f800000);
    wait_done(lat);
    check("y_post_rst", y, 32'h40000000);

    // all-zero operands, exact latency
    launch('0, '0, 32'h0);
    wait_done(lat);
    check("lat_zero", lat, LAT);
    check("y_zero", y, 32'h0);
    check("done_zero", {31'b0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter S, default 32: float width, IEEE-754 single precision.
REQ-002 SHALL have parameter N, default 2: number of input/weight pairs, N >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin one dot-product evaluation.
REQ-006 SHALL have port x, input, S*N bits: input vector, element i at bits [S*(i+1)-1 : S*i].
REQ-007 SHALL have port w, input, S*N bits: weight vector, packed the same way as x.
REQ-008 SHALL have port b, input, S bits: bias.
REQ-009 SHALL have port y, output, S bits: result b + sum(x_i*w_i), which feeds the sigmoid stage's x input.
REQ-010 SHALL have port done, output, 1 bit: y valid.
REQ-011 SHALL have port busy, output, 1 bit: evaluation in progress.
REQ-012 SHALL have port ovf, output, 1 bit: sticky overflow flag for the current evaluation.
REQ-013 SHALL have port nan, output, 1 bit: sticky NaN flag for the current evaluation.

Function
REQ-014 SHALL compute serially with one mul_float and one add_float instance (FLOAT_WIDTH=S); core rst_n tied to rst_n; core start driven as 1-cycle pulses.
REQ-015 SHALL use states IDLE, MUL_GO, MUL_WAIT, ADD_GO, ADD_WAIT, FIN.
REQ-016 SHALL, on start=1 in IDLE or FIN: latch x, w and b into internal registers; set acc=b and index i=0; clear done, ovf and nan; go to MUL_GO.
REQ-017 SHALL ignore start in any other state: no relatch, no restart.
REQ-018 SHALL pulse mul start for one cycle in MUL_GO with operands x_i and w_i, then go to MUL_WAIT.
REQ-019 SHALL, in MUL_WAIT, register the product on mul done, then go to ADD_GO.
REQ-020 SHALL pulse add start for one cycle in ADD_GO (add/sub select = 0, acc + product), then go to ADD_WAIT.
REQ-021 SHALL, in ADD_WAIT on add done: acc <= sum; if i == N-1 go to FIN, else i <= i+1 and go to MUL_GO.
REQ-022 SHALL, in FIN, set y=acc and hold done=1 until the next accepted start or reset.
REQ-023 SHALL drive busy=1 in every state except IDLE and FIN.
REQ-024 SHALL OR the overflow and nan outputs of either core into ovf and nan, sampled on each core done; evaluation continues and y = acc as computed.
REQ-025 SHALL give latency from accepted start to done = N*(Tm+Ta+2)+1 cycles, where Tm and Ta are the core start-to-done cycle counts.
REQ-026 SHALL hold y stable while busy; changes to x, w and b after acceptance have no effect.
REQ-027 SHALL size the index counter as ceil(log2(N)) bits, minimum 1, with no wrap-around past N-1.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-operation: state=IDLE, y=0, done=0, busy=0, ovf=0, nan=0, acc=0, i=0, without waiting for the cores.
REQ-029 SHALL, after rst_n deasserts, not start until a new start pulse.

Verification
REQ-030 Bench SHALL drive x={2.0=40000000, 1.0=3f800000}, w={0.25=3e800000, 0.5=3f000000}, b=3f800000, start -> done=1, y=40000000 (2.0), ovf=0, nan=0.
REQ-031 Bench SHALL drive x={3f800000, 3f800000}, w={c0000000, bf800000}, b=00000000 -> y=c0400000 (-3.0).
REQ-032 Bench SHALL drive x0=7f7fffff, w0=40000000, other terms 0, b=0 -> ovf=1 at done; ovf cleared by the next start.
REQ-033 Bench SHALL issue a second start while busy with changed x -> ignored; y equals the first evaluation's result; exactly one done rise.
REQ-034 Bench SHALL assert rst_n=0 during MUL_WAIT -> all outputs 0 immediately; a later start with the REQ-030 vectors gives y=40000000.
REQ-035 Bench SHALL drive all operands 0 -> y=00000000, done=1 after the REQ-025 latency, measured exactly.
